// File: rtl/sobel_gradient_axis_if.sv
// ---------------------------------------------------------------------------
// sobel_gradient_axis_if
//   AXI-Stream style bundle used on both sides of the gradient engine.
//   W      : tdata width
//   tdata  : payload
//   tvalid : source has a beat
//   tready : sink can take a beat
//   tuser  : first beat of a frame
//   tlast  : last beat of a line
//   master modport drives the payload, slave modport drives tready.
// ---------------------------------------------------------------------------
interface sobel_gradient_axis_if #(
  parameter int W = 8
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tuser;
  logic         tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/sobel_gradient_axis.sv
// ---------------------------------------------------------------------------
// sobel_gradient_axis
//   Streaming 3x3 gradient engine. Consumes an unsigned pixel stream, keeps
//   two line buffers plus a 3x3 window, and emits {Gy,Gx} (signed, Gx in the
//   LSBs) for every interior pixel with full output backpressure.
// Ports
//   i_clk, i_aresetn : clock, asynchronous active-low reset
//   s_axis (slave)   : input pixels, tuser = start of frame, tlast = end of line
//   m_axis (master)  : {Gy,Gx}, tuser = first output of frame, tlast = end of output line
//   i_kernel_sel     : 0 = Sobel, 1 = Prewitt; captured on the tuser beat
//   o_err_line       : sticky tlast/column mismatch, cleared by a tuser beat
//   o_frame_done     : high in the cycle the last output beat of a frame is taken
// ---------------------------------------------------------------------------
module sobel_gradient_axis #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 4096,
  parameter int IMG_HEIGHT = 3072,
  parameter int GRAD_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_aresetn,
  sobel_gradient_axis_if.slave  s_axis,
  sobel_gradient_axis_if.master m_axis,
  input  logic                  i_kernel_sel,
  output logic                  o_err_line,
  output logic                  o_frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  if (GRAD_WIDTH < DATA_WIDTH + 4) begin : g_bad_width
    $error("GRAD_WIDTH must be at least DATA_WIDTH+4");
  end

  typedef enum logic {S_WAIT, S_RUN} state_t;

  state_t                  r_state, w_state_next;
  logic                    r_alive;
  logic [CW-1:0]           r_col, w_col, w_col_next;
  logic [RW-1:0]           r_row, w_row, w_row_next;
  logic                    r_sel, r_err;
  logic                    w_en, w_acc, w_proc, w_col_last, w_row_last, w_mis;

  // line buffers: lb0 holds row r-1, lb1 holds row r-2
  logic [DATA_WIDTH-1:0]   r_lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0]   r_lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0]   r_lb0_rd, r_lb1_rd;
  logic [DATA_WIDTH-1:0]   w_tap_in [3];

  logic [DATA_WIDTH-1:0]   r_win [3][3];
  logic                    r_s1_valid, r_s1_user, r_s1_last, r_s1_fend, r_s1_sel;

  logic signed [GRAD_WIDTH-1:0] w_gx, w_gy, w_mid_r, w_mid_l, w_mid_b, w_mid_t;
  logic                    r_m_valid, r_m_user, r_m_last, r_m_fend;
  logic [2*GRAD_WIDTH-1:0] r_m_data;

  // an output slot is free or being drained this cycle
  assign w_en          = ~r_m_valid | m_axis.tready;
  assign s_axis.tready = w_en & r_alive;
  assign w_acc         = s_axis.tvalid & s_axis.tready;
  // beats before the first tuser (or after a frame end) are dropped
  assign w_proc        = w_acc & (s_axis.tuser | (r_state == S_RUN));
  assign w_col         = s_axis.tuser ? '0 : r_col;
  assign w_row         = s_axis.tuser ? '0 : r_row;
  assign w_col_last    = (w_col == COL_LAST);
  assign w_row_last    = (w_row == ROW_LAST);
  assign w_mis         = s_axis.tlast ^ w_col_last;

  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_row_next   = r_row;
    if (w_proc) begin
      w_state_next = S_RUN;
      w_row_next   = w_row;
      if (w_col_last) begin
        w_col_next = '0;
        if (w_row_last) begin
          w_row_next   = '0;
          w_state_next = S_WAIT;
        end else begin
          w_row_next = w_row + RW'(1);
        end
      end else begin
        w_col_next = w_col + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state <= S_WAIT;
      r_alive <= 1'b0;
      r_col   <= '0;
      r_row   <= '0;
      r_sel   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_alive <= 1'b1;
      r_col   <= w_col_next;
      r_row   <= w_row_next;
      if (w_proc && s_axis.tuser) begin
        r_sel <= i_kernel_sel;
        r_err <= w_mis;
      end else if (w_proc && w_mis) begin
        r_err <= 1'b1;
      end
    end
  end

  // The read address is the column the next processed pixel will use, so the
  // registered read data is ready when that pixel arrives. It never collides
  // with the write of the current pixel because consecutive columns differ.
  always_ff @(posedge i_clk) begin
    if (w_proc) begin
      r_lb0[w_col] <= s_axis.tdata;
      r_lb1[w_col] <= r_lb0_rd;
    end
    r_lb0_rd <= r_lb0[w_col_next];
    r_lb1_rd <= r_lb1[w_col_next];
  end

  assign w_tap_in[0] = r_lb1_rd;
  assign w_tap_in[1] = r_lb0_rd;
  assign w_tap_in[2] = s_axis.tdata;

  // stage 1: window shift plus per-output side-band
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          r_win[i][j] <= '0;
      r_s1_valid <= 1'b0;
      r_s1_user  <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_fend  <= 1'b0;
      r_s1_sel   <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= w_proc & (w_row >= RW'(2)) & (w_col >= CW'(2));
      if (w_proc) begin
        for (int i = 0; i < 3; i++) begin
          r_win[i][0] <= r_win[i][1];
          r_win[i][1] <= r_win[i][2];
          r_win[i][2] <= w_tap_in[i];
        end
        r_s1_user <= (w_row == RW'(2)) && (w_col == CW'(2));
        r_s1_last <= w_col_last;
        r_s1_fend <= w_col_last & w_row_last;
        r_s1_sel  <= s_axis.tuser ? i_kernel_sel : r_sel;
      end
    end
  end

  function automatic logic signed [GRAD_WIDTH-1:0] ext(input logic [DATA_WIDTH-1:0] p);
    return signed'({{(GRAD_WIDTH-DATA_WIDTH){1'b0}}, p});
  endfunction

  // centre taps get weight 2 for Sobel, 1 for Prewitt
  assign w_mid_r = r_s1_sel ? ext(r_win[1][2]) : (ext(r_win[1][2]) <<< 1);
  assign w_mid_l = r_s1_sel ? ext(r_win[1][0]) : (ext(r_win[1][0]) <<< 1);
  assign w_mid_b = r_s1_sel ? ext(r_win[2][1]) : (ext(r_win[2][1]) <<< 1);
  assign w_mid_t = r_s1_sel ? ext(r_win[0][1]) : (ext(r_win[0][1]) <<< 1);
  assign w_gx = (ext(r_win[0][2]) + w_mid_r + ext(r_win[2][2]))
              - (ext(r_win[0][0]) + w_mid_l + ext(r_win[2][0]));
  assign w_gy = (ext(r_win[2][0]) + w_mid_b + ext(r_win[2][2]))
              - (ext(r_win[0][0]) + w_mid_t + ext(r_win[0][2]));

  // stage 2: output register, held while the sink stalls
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_user  <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_fend  <= 1'b0;
    end else if (w_en) begin
      r_m_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_m_data <= {w_gy, w_gx};
        r_m_user <= r_s1_user;
        r_m_last <= r_s1_last;
        r_m_fend <= r_s1_fend;
      end
    end
  end

  assign m_axis.tvalid = r_m_valid;
  assign m_axis.tdata  = r_m_data;
  assign m_axis.tuser  = r_m_user;
  assign m_axis.tlast  = r_m_last;
  assign o_err_line    = r_err;
  assign o_frame_done  = r_m_valid & m_axis.tready & r_m_fend;

endmodule
